// File: rtl/ram2fifo_pkg.sv
// Shared types and default sizing for the RAM-to-FIFO self-test harness.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram2fifo_pkg;
    typedef enum logic [1:0] {IDLE, FILL, XFER, DONE} state_t;

    localparam int          DEF_DW   = 16;
    localparam int          DEF_AW   = 6;
    localparam int          DEF_FAW  = 3;
    localparam logic [15:0] DEF_SEED = 16'hA5A5;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; dout always presents the head entry.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
    parameter int DW  = 16,
    parameter int FAW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [DW-1:0]  din,
    input  logic           pop,
    output logic [DW-1:0]  dout,
    output logic           full,
    output logic           empty,
    output logic [FAW:0]   level
);
    localparam int F = 1 << FAW;

    logic [DW-1:0]  mem [F];
    logic [FAW-1:0] wr_ptr;
    logic [FAW-1:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == (FAW+1)'(F));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push against a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ram2fifo_selftest.sv
// Self-stimulating harness: fill RAM with SEED+a, stream it through a FIFO, drain at 3/4 rate and check.
// Latency: N fill cycles, then roughly 4N/3 transfer cycles to done.
// Backpressure: RAM reads are credit-gated on FIFO occupancy; the consumer idles one cycle in four.
module ram2fifo_selftest
    import ram2fifo_pkg::*;
#(
    parameter int            DW   = DEF_DW,
    parameter int            AW   = DEF_AW,
    parameter int            FAW  = DEF_FAW,
    parameter logic [DW-1:0] SEED = DEF_SEED
) (
    input  logic         clk,
    input  logic         rst,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [AW:0]  word_cnt,
    output logic [FAW:0] fifo_level
);
    localparam int N = 1 << AW;
    localparam int F = 1 << FAW;

    state_t         state;
    logic [AW-1:0]  wr_addr;
    logic [AW:0]    rd_addr;
    logic [1:0]     cc;
    logic [DW-1:0]  ram [N];
    logic [DW-1:0]  rd_dat;
    logic           rd_vld;

    logic           wr_en;
    logic [DW-1:0]  wr_pat;
    logic           rd_issue;
    logic           pop;
    logic [DW-1:0]  fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_err;
    logic [DW-1:0]  exp_dat;
    logic           mismatch;
    logic [FAW+1:0] occ_next;

    // Reset always lands in IDLE, which takes the first fill write on the first clock.
    assign wr_en  = (state == IDLE) || (state == FILL);
    assign wr_pat = SEED + DW'(wr_addr);

    assign pop = (state == XFER) && !fifo_empty && (cc != 2'b11);

    // Occupancy after this edge: the in-flight read lands and this cycle's pop leaves.
    assign occ_next = {1'b0, fifo_level} + (FAW+2)'(rd_vld) - (FAW+2)'(pop);
    assign rd_issue = (state == XFER) && (rd_addr < (AW+1)'(N)) && (occ_next < (FAW+2)'(F));

    assign exp_dat  = SEED + DW'(word_cnt);
    assign mismatch = pop && (fifo_dout != exp_dat);
    assign fifo_err = (rd_vld && fifo_full && !pop) || (pop && fifo_empty);

    always_ff @(posedge clk) begin
        if (wr_en)    ram[wr_addr] <= wr_pat;
        if (rd_issue) rd_dat       <= ram[rd_addr[AW-1:0]];
    end

    sync_fifo #(
        .DW  (DW),
        .FAW (FAW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_vld),
        .din   (rd_dat),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            rd_vld   <= 1'b0;
            cc       <= '0;
            word_cnt <= '0;
        end else begin
            rd_vld <= rd_issue;
            if (fifo_err || mismatch) err <= 1'b1;
            case (state)
                IDLE: begin
                    state   <= FILL;
                    busy    <= 1'b1;
                    wr_addr <= wr_addr + 1'b1;
                end
                FILL: begin
                    wr_addr <= wr_addr + 1'b1;
                    if (wr_addr == AW'(N-1)) begin
                        state <= XFER;
                        cc    <= '0;
                    end
                end
                XFER: begin
                    cc <= cc + 1'b1;
                    if (rd_issue) rd_addr <= rd_addr + 1'b1;
                    if (pop) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == (AW+1)'(N-1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram2fifo_selftest.sv
// Directed bench for ram2fifo_selftest: default instance plus a wrapping-seed instance.
module tb_ram2fifo_selftest;
    logic       clk;
    logic       rst;

    logic       busy_a, done_a, err_a;
    logic [6:0] word_cnt_a;
    logic [3:0] level_a;
    logic       busy_b, done_b, err_b;
    logic [6:0] word_cnt_b;
    logic [3:0] level_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] cap_a [64];
    logic [15:0] cap_b [64];
    int          max_lvl = 0;

    typedef struct {
        string       name;
        bit          inst;
        int          idx;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [8];

    ram2fifo_selftest dut_a (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy_a),
        .done       (done_a),
        .err        (err_a),
        .word_cnt   (word_cnt_a),
        .fifo_level (level_a)
    );

    ram2fifo_selftest #(.SEED(16'hFFF0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy_b),
        .done       (done_b),
        .err        (err_b),
        .word_cnt   (word_cnt_b),
        .fifo_level (level_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut_a.pop) cap_a[word_cnt_a[5:0]] = dut_a.fifo_dout;
        if (dut_b.pop) cap_b[word_cnt_b[5:0]] = dut_b.fifo_dout;
        if (int'(level_a) > max_lvl) max_lvl = int'(level_a);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_word(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(word_cnt_a) == target) break;
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_a) break;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy_a"},  32'(busy_a),     32'd0);
        check({tag, "_done_a"},  32'(done_a),     32'd0);
        check({tag, "_err_a"},   32'(err_a),      32'd0);
        check({tag, "_level_a"}, 32'(level_a),    32'd0);
        check({tag, "_cnt_a"},   32'(word_cnt_a), 32'd0);
        check({tag, "_busy_b"},  32'(busy_b),     32'd0);
        check({tag, "_cnt_b"},   32'(word_cnt_b), 32'd0);
    endtask

    initial begin
        bit held;

        vecs[0] = '{"a_word0",  1'b0, 0,  16'hA5A5};
        vecs[1] = '{"a_word1",  1'b0, 1,  16'hA5A6};
        vecs[2] = '{"a_word10", 1'b0, 10, 16'hA5AF};
        vecs[3] = '{"a_word63", 1'b0, 63, 16'hA5E4};
        vecs[4] = '{"b_word0",  1'b1, 0,  16'hFFF0};
        vecs[5] = '{"b_word15", 1'b1, 15, 16'hFFFF};
        vecs[6] = '{"b_word16", 1'b1, 16, 16'h0000};
        vecs[7] = '{"b_word63", 1'b1, 63, 16'h002F};

        // Run 1: power-on reset, defaults to completion.
        rst = 1'b0;
        #29;
        check_reset_outputs("por");
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_release", 32'(busy_a), 32'd1);
        check("done_after_release", 32'(done_a), 32'd0);
        check("err_after_release",  32'(err_a),  32'd0);
        check("level_after_release", 32'(level_a), 32'd0);

        wait_done(1000);
        check("run1_done_a",  32'(done_a),     32'd1);
        check("run1_cnt_a",   32'(word_cnt_a), 32'd64);
        check("run1_err_a",   32'(err_a),      32'd0);
        check("run1_busy_a",  32'(busy_a),     32'd0);
        check("run1_level_a", 32'(level_a),    32'd0);
        check("run1_done_b",  32'(done_b),     32'd1);
        check("run1_err_b",   32'(err_b),      32'd0);
        check("run1_max_level", 32'(max_lvl),  32'd8);

        held = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (!done_a || busy_a) held = 1'b0;
        end
        check("done_hold", 32'(held), 32'd1);

        for (int i = 0; i < 8; i++) begin
            logic [15:0] act;
            act = vecs[i].inst ? cap_b[vecs[i].idx] : cap_a[vecs[i].idx];
            check(vecs[i].name, 32'(act), 32'(vecs[i].exp));
        end

        // Run 2: flip one bit of RAM word 10 after the fill has written it.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst2");
        #1 rst = 1'b1;
        repeat (66) @(posedge clk);
        #1 dut_a.ram[10] <= dut_a.ram[10] ^ 16'h0004;
        wait_word(10, 500);
        check("flip_cnt10", 32'(word_cnt_a), 32'd10);
        check("flip_err_before", 32'(err_a), 32'd0);
        wait_word(11, 50);
        check("flip_cnt11", 32'(word_cnt_a), 32'd11);
        check("flip_err_at_11", 32'(err_a), 32'd1);
        wait_done(1000);
        check("flip_done", 32'(done_a), 32'd1);
        check("flip_err_sticky", 32'(err_a), 32'd1);
        check("flip_err_b", 32'(err_b), 32'd0);

        // Run 3: abort mid-transfer with an asynchronous reset, then rerun.
        @(negedge clk);
        rst = 1'b0;
        #2 rst = 1'b1;
        wait_word(20, 500);
        check("abort_cnt20", 32'(word_cnt_a), 32'd20);
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        #2 rst = 1'b1;
        wait_done(1000);
        check("rerun_done", 32'(done_a),     32'd1);
        check("rerun_err",  32'(err_a),      32'd0);
        check("rerun_cnt",  32'(word_cnt_a), 32'd64);
        check("rerun_busy", 32'(busy_a),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
